// File: rtl/serial_mult_abortable.sv
// Shift-add serial multiplier with start/done handshake and a synchronous abort.
// Define SERIAL_MULT_SIGNED_EN for two's-complement operands and result.
module serial_mult_abortable #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [2*WIDTH-1:0] y
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic                 ready_next, busy_next, done_next, aborted_next;
    logic [WIDTH-1:0]     mcand, mplier, acc;
    logic [CW-1:0]        count;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   product, result;
    logic [WIDTH-1:0]     a_cap, b_cap;
    logic                 accept, step, last_step;

`ifdef SERIAL_MULT_SIGNED_EN
    logic neg;

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    assign a_cap  = a[WIDTH-1] ? -a : a;
    assign b_cap  = b[WIDTH-1] ? -b : b;
    assign result = neg ? -product : product;
`else
    assign a_cap  = a;
    assign b_cap  = b;
    assign result = product;
`endif

    assign accept    = (state == S_IDLE) && ready && start;
    assign step      = (state == S_RUN) && !abort;
    assign last_step = step && (count == CW'(1));

    // The carry out of the add becomes the top bit of the shifted chain.
    assign sum     = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign product = {sum, mplier[WIDTH-1:1]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        aborted_next = 1'b0;
        case (state)
            S_IDLE: if (accept) state_next = S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_next   = S_IDLE;
                    aborted_next = 1'b1;
                end else if (count == CW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        ready_next = (state_next == S_IDLE);
        busy_next  = (state_next == S_RUN);
        done_next  = (state_next == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ready   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            y       <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
`ifdef SERIAL_MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            ready   <= ready_next;
            busy    <= busy_next;
            done    <= done_next;
            aborted <= aborted_next;
            if (accept) begin
                mcand  <= a_cap;
                mplier <= b_cap;
                acc    <= '0;
                count  <= CW'(WIDTH);
`ifdef SERIAL_MULT_SIGNED_EN
                neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            end else if (step) begin
                acc    <= sum[WIDTH:1];
                mplier <= {sum[0], mplier[WIDTH-1:1]};
                count  <= count - CW'(1);
            end
            // The final step's product goes straight to y so it is visible with done.
            if (last_step) y <= result;
        end
    end

endmodule

// File: tb/tb_serial_mult_abortable.sv
// Directed self-checking bench for serial_mult_abortable (WIDTH=8).
// Signed vectors run when SERIAL_MULT_SIGNED_EN is defined.
module tb_serial_mult_abortable;

    localparam int WIDTH = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              ready, busy, done, aborted;
    logic [2*WIDTH-1:0] y;

    int checks = 0;
    int errors = 0;

    serial_mult_abortable #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .y       (y)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] expected);
        chk(tag, {28'd0, ready, busy, done, aborted}, {28'd0, expected});
    endtask

    // Full product from an IDLE cycle: start accepted at edge E, done after E+WIDTH.
    task automatic run_product(input string tag, input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb, input logic [2*WIDTH-1:0] expected);
        a = ta; b = tb; start = 1'b1;
        tick();
        start = 1'b0;
        chk_flags({tag, "_busy0"}, 4'b0100);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            chk_flags({tag, "_busy"}, 4'b0100);
        end
        tick();
        chk_flags({tag, "_done"}, 4'b0010);
        chk({tag, "_y"}, {16'd0, y}, {16'd0, expected});
        tick();
        chk_flags({tag, "_ready"}, 4'b1000);
        chk({tag, "_y_hold"}, {16'd0, y}, {16'd0, expected});
    endtask

    initial begin
        // Reset state
        #2;
        chk_flags("reset_flags", 4'b0000);
        chk("reset_y", {16'd0, y}, 32'd0);
        tick();
        reset = 1'b0;
        #2;
        chk_flags("post_reset_flags", 4'b0000);
        tick();
        chk_flags("ready_after_reset", 4'b1000);

        // Basic product 3*5
        run_product("basic", 8'd3, 8'd5, 16'd15);

        // Abort 7*9 on the 3rd RUN edge
        a = 8'd7; b = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_flags("abort_flags", 4'b1001);
        chk("abort_y_kept", {16'd0, y}, 32'd15);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_flags("abort_restart", 4'b0100);
        for (int i = 1; i < WIDTH; i++) tick();
        tick();
        chk_flags("restart_done", 4'b0010);
        chk("restart_y", {16'd0, y}, 32'd63);
        tick();
        chk_flags("restart_ready", 4'b1000);

        // Maximum operands, then start held through DONE into the IDLE cycle
        a = 8'd255; b = 8'd255; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= WIDTH; i++) tick();
        chk_flags("max_done", 4'b0010);
        chk("max_y", {16'd0, y}, 32'h0000FE01);
        a = 8'd0; b = 8'd200; start = 1'b1;
        tick();
        chk_flags("start_ignored_in_done", 4'b1000);
        tick();
        start = 1'b0;
        chk_flags("b2b_accept", 4'b0100);
        for (int i = 1; i <= WIDTH; i++) tick();
        chk_flags("b2b_done", 4'b0010);
        chk("b2b_y", {16'd0, y}, 32'd0);
        tick();

        // Start while busy is ignored; latency unchanged
        a = 8'd2; b = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'd15; b = 8'd15; start = 1'b1;
        tick();
        start = 1'b0;
        chk_flags("busy_start_ignored", 4'b0100);
        for (int i = 3; i < WIDTH; i++) tick();
        chk_flags("busy_start_latency", 4'b0100);
        tick();
        chk_flags("busy_start_done", 4'b0010);
        chk("busy_start_y", {16'd0, y}, 32'd8);
        tick();

        // Abort on the final RUN edge
        a = 8'd10; b = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < WIDTH; i++) tick();
        chk_flags("final_abort_pre", 4'b0100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_flags("final_abort_flags", 4'b1001);
        chk("final_abort_y", {16'd0, y}, 32'd8);
        tick();
        chk_flags("final_abort_after", 4'b1000);

        // Asynchronous reset during RUN
        a = 8'd5; b = 8'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_flags("midrun_reset_flags", 4'b0000);
        chk("midrun_reset_y", {16'd0, y}, 32'd0);
        tick();
        chk_flags("midrun_reset_held", 4'b0000);
        reset = 1'b0;
        tick();
        chk_flags("midrun_reset_ready", 4'b1000);
        run_product("after_reset", 8'd6, 8'd7, 16'd42);

`ifdef SERIAL_MULT_SIGNED_EN
        run_product("signed_m3x5", 8'hFD, 8'd5, 16'hFFF1);
        run_product("signed_m128sq", 8'h80, 8'h80, 16'h4000);
`else
        run_product("unsigned_253x5", 8'd253, 8'd5, 16'd1265);
        run_product("unsigned_128sq", 8'h80, 8'h80, 16'h4000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mult_abortable.md
# serial_mult_abortable

Synthesizable shift-add serial multiplier with a start/done handshake and a synchronous abort input. It is the hardware stage that consumes the `a`/`b` operands behind the `multiply` task. It replaces the task's behavioural `disable` with an explicit abort request that cancels an in-flight product cleanly. Downstream logic receives `y` together with a one-cycle `done` strobe.

## Interface
- `WIDTH`, default 8: operand width in bits; product is `2*WIDTH` bits.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `start` in 1: request a multiply; sampled only while `ready`=1.
- `abort` in 1: cancel the in-flight multiply; sampled only while `busy`=1.
- `a` in `WIDTH`: multiplicand; captured on the accepted `start` edge.
- `b` in `WIDTH`: multiplier; captured on the accepted `start` edge.
- `ready` out 1: high in IDLE, when `start` will be accepted.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse; `y` holds a new product.
- `aborted` out 1: one-cycle pulse confirming a cancel.
- `y` out `2*WIDTH`: last completed product; held until the next completion.

## Operation
- The block has three states: IDLE, RUN and DONE.
- **IDLE** (`ready`=1):
  - `start`=1 at an edge latches `a`, `b`, clears the accumulator, loads the bit counter with `WIDTH`, and moves to RUN.
  - `abort` is ignored in IDLE.
- **RUN** (`busy`=1), per cycle:
  - If multiplier LSB=1, the accumulator upper half gains the multiplicand, carry-extended by one bit.
  - The {carry, accumulator, multiplier} chain shifts right by 1.
  - The counter decrements.
  - When the counter reaches 1 at an edge, that edge performs the last step and moves to DONE.
- **DONE**:
  - `y` is loaded from the accumulator.
  - `done`=1 for this single cycle.
  - The next edge returns to IDLE unconditionally; `start` is not accepted in DONE.
- **Abort**: `abort`=1 at any RUN edge, including the final one, returns to IDLE.
  - `aborted` pulses for one cycle.
  - `y` keeps its previous value and `done` stays low.
  - Abort has priority over completion.
- `start` while `busy` or in DONE is ignored, not queued.
- Inputs `a` and `b` may change freely after the accepted `start` edge.
- Arithmetic is unsigned; the full `2*WIDTH`-bit product is produced with no truncation or overflow.

## Timing
- **Reset values**: `ready`=0, `busy`=0, `done`=0, `aborted`=0, `y`=0, state IDLE.
  - `ready` rises at the first clock edge after `reset` deasserts.
- **Latency**, with `start` accepted at edge E:
  - `busy` is high after edges E … E+WIDTH-1.
  - DONE is entered at edge E+WIDTH; `done` and the new `y` are visible after that edge.
  - `ready` returns after edge E+WIDTH+1.
- **Throughput**: one product per `WIDTH`+2 cycles, with `start` held or re-asserted on the IDLE cycle.
- **Abort timing**: `abort` sampled at edge K returns to IDLE and raises `aborted` after edge K.
  - `ready`=1 in that same cycle, so a new `start` is accepted at edge K+1.
- **Reset mid-operation**: `reset` assertion during RUN or DONE clears everything asynchronously.
  - No `done` or `aborted` pulse is produced.
  - `y` becomes 0.
- `ready`, `busy`, `done` and `aborted` are mutually exclusive, except that all are 0 during and just after reset.

## Configuration
- Macro: `SERIAL_MULT_SIGNED_EN`.
- **Defined**: `a`, `b` and `y` are two's-complement.
  - Operand magnitudes are taken at capture and the result sign is stored.
  - The product is conditionally negated when loaded into `y` in DONE.
  - Latency and the handshake are identical to the unsigned build.
- **Undefined**: operands and result are unsigned.

## Test plan
- **Basic product**: WIDTH=8, `a`=3, `b`=5, `start` pulse at edge 0.
  - Required: `busy` for 8 cycles, `done` pulse after edge 8, `y`=15, `ready` after edge 9.
- **Maximum operands**: `a`=255, `b`=255.
  - Required: `y`=65025 (0xFE01).
  - Back-to-back `start` on the IDLE cycle: `a`=0, `b`=200 gives `y`=0 with a second `done` pulse.
- **Abort**: after the 3·5 product, start 7×9 and assert `abort` on the 3rd RUN edge.
  - Required: `aborted` pulse, no `done`, `y` stays 15, `ready` the same cycle.
  - A fresh `start` on the next edge completes normally with `y`=63.
- **Ignored start and final-edge abort**: pulse `start` with new operands while `busy`.
  - Required: no effect on the running product or its latency.
  - `abort` on the final RUN edge: `aborted`=1, `done`=0, `y` unchanged.
- **Reset mid-run**: assert `reset` asynchronously during RUN.
  - Required: all outputs 0 immediately, no pulses; first `start` after release works normally.
- **Signed build** (`SERIAL_MULT_SIGNED_EN` defined), WIDTH=8:
  - `a`=-3, `b`=5 gives `y`=0xFFF1 (-15).
  - `a`=-128, `b`=-128 gives `y`=0x4000 (16384).
